// File: rtl/ram4k_pkg.sv
// rtl/ram4k_pkg.sv - shared constants and state type for the RAM4K burst reader
package ram4k_pkg;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 16;
    localparam int RAM4K_DEPTH  = 4096;
    localparam int READ_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/ram4k_reader_fifo.sv
// rtl/ram4k_reader_fifo.sv - two-entry word buffer between the RAM read port and the stream
module ram4k_reader_fifo #(
    parameter int DATA_W = ram4k_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem0;
    logic [DATA_W-1:0] mem1;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = rd_ptr ? mem1 : mem0;

    // Storage is cleared on reset so the stream output reads zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) begin
                    mem1 <= din;
                end else begin
                    mem0 <= din;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram4k_reader.sv
// rtl/ram4k_reader.sv - burst reader streaming consecutive RAM4K words with ready/valid flow control
module ram4k_reader #(
    parameter int ADDR_W = ram4k_pkg::ADDR_W,
    parameter int DATA_W = ram4k_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              data_last
);

    import ram4k_pkg::reader_state_t;
    import ram4k_pkg::ST_IDLE;
    import ram4k_pkg::ST_RUN;
    import ram4k_pkg::ST_DRAIN;

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    reader_state_t     state;
    reader_state_t     state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   xfer_left;
    logic              inflight;
    logic              done_q;
    logic              done_nxt;
    logic              accept;
    logic              issue;
    logic              pop;
    logic [2:0]        occ;
    logic              fifo_full;
    logic              fifo_empty;

    assign data_valid  = !fifo_empty;
    assign pop         = data_valid && data_ready;
    assign data_last   = data_valid && (xfer_left == ONE);
    assign busy        = (state != ST_IDLE);
    assign done        = done_q;
    assign ram_load    = 1'b0;
    assign ram_in      = '0;
    assign ram_address = issue ? cur_addr : last_addr;

    // Occupancy after this cycle's pop plus the word on ram_out; keeping it under
    // two guarantees the buffer has room for every word already requested.
    assign occ = {1'b0, fifo_full, !fifo_full && !fifo_empty}
               + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                issue = (occ < 3'd2);
                if (issue && issue_left == ONE) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && xfer_left == ONE) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            last_addr  <= '0;
            issue_left <= '0;
            xfer_left  <= '0;
            inflight   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done_q   <= done_nxt;
            if (accept) begin
                cur_addr   <= base_addr;
                issue_left <= length;
                xfer_left  <= length;
            end else begin
                if (issue) begin
                    cur_addr   <= cur_addr + ADDR_W'(1);
                    last_addr  <= cur_addr;
                    issue_left <= issue_left - ONE;
                end
                if (pop) begin
                    xfer_left <= xfer_left - ONE;
                end
            end
        end
    end

    ram4k_reader_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (ram_out),
        .pop   (pop),
        .dout  (data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/ram4k_reader.md
RAM4K_READER -- requirements
Module: ram4k_reader

Interface
REQ-001 Parameter: ADDR_W, 12, RAM4K address width.
REQ-002 Parameter: DATA_W, 16, RAM4K word width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  one-cycle request to begin a burst read.
REQ-006 Port: base_addr  input  ADDR_W  first word address; sampled when start is accepted.
REQ-007 Port: length  input  ADDR_W+1  word count 0..4096; sampled when start is accepted.
REQ-008 Port: busy  output  1  high from start acceptance until the last word is consumed.
REQ-009 Port: done  output  1  one-cycle pulse when the burst completes.
REQ-010 Port: ram_address  output  ADDR_W  address driven to the RAM4K.
REQ-011 Port: ram_load  output  1  RAM write enable; held 0 at all times.
REQ-012 Port: ram_in  output  DATA_W  RAM write data; held 0 at all times.
REQ-013 Port: ram_out  input  DATA_W  RAM read data; valid one cycle after ram_address is presented.
REQ-014 Port: data  output  DATA_W  streamed word.
REQ-015 Port: data_valid  output  1  data holds a valid word.
REQ-016 Port: data_ready  input  1  consumer accepts; transfer when data_valid and data_ready are both high.
REQ-017 Port: data_last  output  1  high with the final word of the burst.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on accepted start with length>0; RUN->DRAIN once all reads are issued; DRAIN->IDLE when the last word transfers.
REQ-019 start is accepted only in IDLE; start while busy is ignored and has no effect on the burst in progress.
REQ-020 start with length=0: no RAM reads, no data_valid, busy stays 0, done pulses in the cycle after start.
REQ-021 Read latency is fixed at 1 cycle; the word for an address issued in cycle N is captured from ram_out at the edge ending cycle N+1.
REQ-022 Words are buffered in a 2-entry FIFO; a read is issued only when FIFO occupancy plus in-flight reads is less than 2, so no word is ever dropped.
REQ-023 With data_ready held high, throughput is one word per cycle; the first data_valid is asserted 2 cycles after start acceptance.
REQ-024 Addresses increment by 1 modulo 2^ADDR_W; 4095 wraps to 0 within a burst.
REQ-025 length=4096 reads each address exactly once, starting at base_addr.
REQ-026 data and data_last are held stable while data_valid=1 and data_ready=0.
REQ-027 data_last is high only on the length-th word; done pulses in the cycle after that word transfers, and busy falls in the same cycle.
REQ-028 ram_address holds its last issued value when no read is issued.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, FIFO empty, busy=0, done=0, data_valid=0, data_last=0, data=0, ram_address=0.
REQ-030 Reset mid-burst abandons the burst silently with no done pulse; after release the block is idle and accepts start on the first clock edge.

Structure
REQ-031 Shared package ram4k_pkg holds ADDR_W, DATA_W, RAM4K_DEPTH (4096), READ_LATENCY (1) and the reader state enumeration.
REQ-032 The 2-entry buffer is a sub-module, ram4k_reader_fifo, with push/pop/full/empty and the same clk/rst_n.

Verification (bench pairs the DUT with fast_ram4k preloaded via its write port)
REQ-033 Preload addr 1..4 with 1,3,7,15; start base=1, length=4, ready=1 -> data 1,3,7,15 on 4 consecutive cycles, data_last on 15, done one cycle later.
REQ-034 Preload 4094=0xAAAA, 4095=0xBBBB, 0=0xCCCC; base=4094, length=3 -> 0xAAAA,0xBBBB,0xCCCC (wrap verified).
REQ-035 Same burst as REQ-033 with data_ready toggling 1,0,0,1 -> identical sequence, data stable across stall cycles, no loss, no duplication.
REQ-036 length=0 -> done pulse next cycle, data_valid never asserted, ram_address unchanged.
REQ-037 rst_n low after the 2nd word of a length-8 burst -> outputs zero immediately, no done; new burst base=0x200, length=1 returns mem[0x200].
REQ-038 start pulsed during a burst with different base -> ignored; original burst completes unchanged; ram_load is 0 throughout every test.
